// File: rtl/fb_seq_pkg.sv
// Shared types and constants for the feedback timing sequencer.
package fb_seq_pkg;
    localparam int SEQ_CW      = 8;
    localparam int SEQ_NBW     = 3;
    localparam int SEQ_MW      = 8;
    localparam int SEQ_CLR_LEN = 2;

    localparam int DEF_COND_START = 17;
    localparam int DEF_COND_LEN   = 2;
    localparam int DEF_DAC_START  = 20;
    localparam int DEF_DAC_LEN    = 2;
    localparam int DEF_NUM_BUNCH  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_DONE,
        ST_CLEAR
    } seq_state_t;
endpackage

// File: rtl/fb_window_decode.sv
// Registered window gate: high the cycle after cnt lies in [start, start+len-1] while enabled.
module fb_window_decode
    import fb_seq_pkg::*;
#(
    parameter int CW = SEQ_CW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [CW:0]   cnt_i,
    input  logic [CW-1:0] start_i,
    input  logic [CW-1:0] len_i,
    input  logic          win_en_i,
    input  logic          force_on_i,
    input  logic          fb_en_i,
    output logic          gate_o
);
    logic [CW:0] stop;
    logic        hit;
    logic        gate_q;

    // Window bounds are CW+1 bits wide so start+len never wraps.
    assign stop = {1'b0, start_i} + {1'b0, len_i};
    assign hit  = (cnt_i >= {1'b0, start_i}) && (cnt_i < stop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= fb_en_i && ((win_en_i && hit) || force_on_i);
        end
    end

    assign gate_o = gate_q;
endmodule

// File: rtl/fb_timing_sequencer.sv
// Bunch-strobe driven sequencer for the feedback calc gate and DAC update clock.
// state | meaning
// IDLE  | waiting for store window; ARMED | waiting for bunch strobe
// RUN   | counting, windows live;     DONE  | all bunches served, hold
// CLEAR | end-of-store DAC clear pulse
module fb_timing_sequencer
    import fb_seq_pkg::*;
#(
    parameter int CW      = SEQ_CW,
    parameter int NBW     = SEQ_NBW,
    parameter int MW      = SEQ_MW,
    parameter int CLR_LEN = SEQ_CLR_LEN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           store_strb,
    input  logic           bunch_strb,
    input  logic           fb_en,
    input  logic [CW-1:0]  cond_start,
    input  logic [CW-1:0]  cond_len,
    input  logic [CW-1:0]  dac_start,
    input  logic [CW-1:0]  dac_len,
    input  logic [NBW-1:0] num_bunches,
    input  logic           dsp_oflow,
    output logic           fb_cond,
    output logic           dac_clk,
    output logic           busy,
    output logic [NBW-1:0] bunch_idx,
    output logic           oflow_sticky,
    output logic [MW-1:0]  missed_cnt
);
    localparam int              CLRW     = $clog2(CLR_LEN + 1);
    localparam logic [CW:0]     CNT_ONE  = 1;
    localparam logic [NBW:0]    NB_ONE   = 1;
    localparam logic [MW-1:0]   MISS_ONE = 1;
    localparam logic [CLRW-1:0] CLR_ONE  = 1;
    localparam logic [CLRW-1:0] CLR_LOAD = CLRW'(CLR_LEN - 1);

    seq_state_t      state_q, state_d;
    logic            store_q;
    logic [CW:0]     cnt_q, cnt_d;
    logic [CW-1:0]   cs_q, cs_d, cl_q, cl_d, ds_q, ds_d, dl_q, dl_d;
    logic [NBW-1:0]  nb_q, nb_d, bidx_q, bidx_d;
    logic            oflow_q, oflow_d, busy_q;
    logic [MW-1:0]   missed_q, missed_d;
    logic [CLRW-1:0] clr_q, clr_d;

    logic            fall, at_end, run_win, clr_next;
    logic [CW:0]     cond_stop, dac_stop, last_stop, end_cnt;
    logic [NBW:0]    nb_eff, bidx_inc;
    logic [MW-1:0]   missed_inc;

    assign fall       = store_q & ~store_strb;
    assign cond_stop  = {1'b0, cs_q} + {1'b0, cl_q};
    assign dac_stop   = {1'b0, ds_q} + {1'b0, dl_q};
    assign last_stop  = (cond_stop > dac_stop) ? cond_stop : dac_stop;
    assign end_cnt    = (last_stop == '0) ? '0 : last_stop - CNT_ONE;
    // cnt starts at 1, so >= also terminates a degenerate end of 0.
    assign at_end     = (cnt_q >= end_cnt);
    assign nb_eff     = (nb_q == '0) ? NB_ONE : {1'b0, nb_q};
    assign bidx_inc   = {1'b0, bidx_q} + NB_ONE;
    assign missed_inc = (missed_q == '1) ? missed_q : missed_q + MISS_ONE;
    assign run_win    = (state_q == ST_RUN) && !fall;
    assign clr_next   = (state_d == ST_CLEAR);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cs_d     = cs_q;
        cl_d     = cl_q;
        ds_d     = ds_q;
        dl_d     = dl_q;
        nb_d     = nb_q;
        bidx_d   = bidx_q;
        oflow_d  = oflow_q;
        missed_d = missed_q;
        clr_d    = clr_q;
        if (state_q == ST_RUN && dsp_oflow) begin
            oflow_d = 1'b1;
        end
        if (fall && (state_q == ST_ARMED || state_q == ST_RUN || state_q == ST_DONE)) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            clr_d   = CLR_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (store_strb) begin
                        cs_d     = cond_start;
                        cl_d     = cond_len;
                        ds_d     = dac_start;
                        dl_d     = dac_len;
                        nb_d     = num_bunches;
                        bidx_d   = '0;
                        oflow_d  = 1'b0;
                        missed_d = '0;
                        state_d  = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (bunch_strb) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bunch_strb) begin
                        missed_d = missed_inc;
                    end
                    if (at_end) begin
                        bidx_d  = bidx_inc[NBW-1:0];
                        cnt_d   = '0;
                        state_d = (bidx_inc >= nb_eff) ? ST_DONE : ST_ARMED;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (bunch_strb) begin
                        missed_d = missed_inc;
                    end
                end
                ST_CLEAR: begin
                    if (clr_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        clr_d = clr_q - CLR_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            store_q  <= 1'b0;
            cnt_q    <= '0;
            cs_q     <= CW'(DEF_COND_START);
            cl_q     <= CW'(DEF_COND_LEN);
            ds_q     <= CW'(DEF_DAC_START);
            dl_q     <= CW'(DEF_DAC_LEN);
            nb_q     <= NBW'(DEF_NUM_BUNCH);
            bidx_q   <= '0;
            oflow_q  <= 1'b0;
            missed_q <= '0;
            clr_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_strb;
            cnt_q    <= cnt_d;
            cs_q     <= cs_d;
            cl_q     <= cl_d;
            ds_q     <= ds_d;
            dl_q     <= dl_d;
            nb_q     <= nb_d;
            bidx_q   <= bidx_d;
            oflow_q  <= oflow_d;
            missed_q <= missed_d;
            clr_q    <= clr_d;
            busy_q   <= (state_d == ST_RUN);
        end
    end

    fb_window_decode #(.CW(CW)) u_cond_win (
        .clk_i      (clk),
        .rst_i      (rst),
        .cnt_i      (cnt_q),
        .start_i    (cs_q),
        .len_i      (cl_q),
        .win_en_i   (run_win),
        .force_on_i (1'b0),
        .fb_en_i    (fb_en),
        .gate_o     (fb_cond)
    );

    fb_window_decode #(.CW(CW)) u_dac_win (
        .clk_i      (clk),
        .rst_i      (rst),
        .cnt_i      (cnt_q),
        .start_i    (ds_q),
        .len_i      (dl_q),
        .win_en_i   (run_win),
        .force_on_i (clr_next),
        .fb_en_i    (fb_en),
        .gate_o     (dac_clk)
    );

    assign busy         = busy_q;
    assign bunch_idx    = bidx_q;
    assign oflow_sticky = oflow_q;
    assign missed_cnt   = missed_q;
endmodule
